keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 167 ++++++++++++++++
 tb/tb_keypad_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_encoder
//  Description : Debounced keypad encoder. Each key is synchronised and
//                debounced; presses are queued as codes (key index + 1) in a
//                small FIFO, lowest index first when several are pending.
//                Also reports the code of the currently held keys and a
//                sticky flag for presses merged while still pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder #(
  parameter int NUM_KEYS        = 9,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [CODE_W-1:0]   ev_code,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [CODE_W-1:0]   held_code,
  output logic                overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  generate
    if ((1 << CODE_W) < NUM_KEYS + 1) begin : g_chk_code_w
      $error("keypad_encoder: CODE_W too small for NUM_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
      $error("keypad_encoder: DEBOUNCE_CYCLES must be >= 1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("keypad_encoder: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  // A key may only generate a press after it has been seen released since
  // reset, so keys held through a reset do not produce a stale event.
  logic [NUM_KEYS-1:0] armed_q, armed_d;
  // Counts the synchroniser refill after reset; s2 is trusted once bit 1 is set.
  logic [1:0]          warm_q, warm_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0]   mem_d [FIFO_DEPTH];
  logic [CODE_W-1:0]   held_code_q, held_code_d;
  logic                overflow_q, overflow_d;

  logic [NUM_KEYS-1:0] rise, press, clr;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CODE_W-1:0]   push_code;
  logic                push, pop;

  assign ev_valid  = (count_q != '0);
  assign ev_code   = mem_q[rd_ptr_q];
  assign held_code = held_code_q;
  assign overflow  = overflow_q;

  // Next-state: synchroniser, debounce, press arbitration and FIFO control.
  always_comb begin
    s1_d        = keys;
    s2_d        = s1_q;
    deb_d       = deb_q;
    cnt_d       = cnt_q;
    rise        = '0;
    cnt_inc     = '0;
    warm_d      = warm_q;
    push_code   = '0;
    clr         = '0;
    held_code_d = '0;
    mem_d       = mem_q;

    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_inc = cnt_q[i] + CNT_W'(1);
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_inc == DEB_LIMIT) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
        rise[i]  = ~deb_q[i];
      end else begin
        cnt_d[i] = cnt_inc;
      end
    end

    if (!warm_q[1]) begin
      warm_d = warm_q + 2'd1;
    end
    armed_d    = armed_q | (warm_q[1] ? ~s2_q : '0);
    press      = rise & armed_q;
    overflow_d = overflow_q | (|(press & pending_q));

    // Scan downwards so the lowest pending index wins.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_code = CODE_W'(i + 1);
        clr       = NUM_KEYS'(1) << i;
      end
      if (deb_q[i]) begin
        held_code_d = CODE_W'(i + 1);
      end
    end

    pop  = ev_valid & ev_ready;
    push = (|pending_q) & ((count_q != FIFO_FULL) | pop);

    pending_d = (pending_q | press) & ~(push ? clr : '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_code;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      deb_q       <= '0;
      pending_q   <= '0;
      armed_q     <= '0;
      warm_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      held_code_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      warm_q      <= warm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      held_code_q <= held_code_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_encoder
//  Description : Directed self-checking bench for keypad_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

  localparam int NK = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] keys;
  logic [CW-1:0] ev_code;
  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] held_code;
  logic          overflow;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  keypad_encoder #(
    .NUM_KEYS        (NK),
    .CODE_W          (CW),
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .ev_code   (ev_code),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .held_code (held_code),
    .overflow  (overflow)
  );

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    keys     = '0;
    ev_ready = 1'b0;
    step(2);
    check("rst_valid", 8'(ev_valid), 8'd0);
    check("rst_held", 8'(held_code), 8'd0);
    check("rst_ovf", 8'(overflow), 8'd0);

    // Inputs wiggling while in reset must not disturb outputs.
    keys     = '1;
    ev_ready = 1'b1;
    step(3);
    check("rst_hold_valid", 8'(ev_valid), 8'd0);
    check("rst_hold_held", 8'(held_code), 8'd0);
    check("rst_hold_ovf", 8'(overflow), 8'd0);
    keys     = '0;
    ev_ready = 1'b0;
    rst_n    = 1'b1;
    step(4);
    check("idle_valid", 8'(ev_valid), 8'd0);

    // Single press on key 5: deb at edge 6, push at edge 7.
    keys[4] = 1'b1;
    step(6);
    check("k5_valid_e6", 8'(ev_valid), 8'd0);
    check("k5_held_e6", 8'(held_code), 8'd0);
    step(1);
    check("k5_valid_e7", 8'(ev_valid), 8'd1);
    check("k5_code", 8'(ev_code), 8'd5);
    check("k5_held", 8'(held_code), 8'd5);
    step(5);
    check("k5_valid_hold", 8'(ev_valid), 8'd1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check("k5_single", 8'(ev_valid), 8'd0);
    keys[4] = 1'b0;
    step(8);
    check("k5_rel_held", 8'(held_code), 8'd0);
    check("k5_rel_valid", 8'(ev_valid), 8'd0);

    // Bounce: key 2 high for 3 cycles only.
    keys[1] = 1'b1;
    step(3);
    keys[1] = 1'b0;
    step(3);
    check("bounce_held_a", 8'(held_code), 8'd0);
    step(7);
    check("bounce_held_b", 8'(held_code), 8'd0);
    check("bounce_valid", 8'(ev_valid), 8'd0);

    // Keys 8 and 3 together: event 3 then 8.
    keys[7] = 1'b1;
    keys[2] = 1'b1;
    step(7);
    check("dual_valid", 8'(ev_valid), 8'd1);
    check("dual_code_a", 8'(ev_code), 8'd3);
    check("dual_held", 8'(held_code), 8'd3);
    step(1);
    check("dual_head_kept", 8'(ev_code), 8'd3);
    ev_ready = 1'b1;
    step(1);
    check("dual_valid_b", 8'(ev_valid), 8'd1);
    check("dual_code_b", 8'(ev_code), 8'd8);
    step(1);
    check("dual_empty", 8'(ev_valid), 8'd0);
    ev_ready = 1'b0;
    keys     = '0;
    step(8);

    // Full FIFO popped on the same edge as a new push.
    keys[1] = 1'b1; step(8);
    keys[3] = 1'b1; step(8);
    keys[5] = 1'b1; step(8);
    keys[7] = 1'b1; step(8);
    check("full_head", 8'(ev_code), 8'd2);
    keys[0] = 1'b1;
    step(6);
    ev_ready = 1'b1;
    step(1);
    check("full_pp_valid", 8'(ev_valid), 8'd1);
    check("full_pp_code", 8'(ev_code), 8'd4);
    check("full_pp_ovf", 8'(overflow), 8'd0);
    step(1);
    check("full_drain_6", 8'(ev_code), 8'd6);
    step(1);
    check("full_drain_8", 8'(ev_code), 8'd8);
    step(1);
    check("full_drain_1", 8'(ev_code), 8'd1);
    step(1);
    check("full_drain_empty", 8'(ev_valid), 8'd0);
    step(2);
    check("ready_when_empty", 8'(ev_valid), 8'd0);
    ev_ready = 1'b0;
    keys     = '0;
    step(8);

    // Five presses: fifth waits pending, re-press sets overflow.
    keys[4] = 1'b1; step(8);
    keys[0] = 1'b1; step(8);
    keys[6] = 1'b1; step(8);
    keys[2] = 1'b1; step(8);
    keys[8] = 1'b1; step(8);
    check("five_head", 8'(ev_code), 8'd5);
    check("five_held", 8'(held_code), 8'd1);
    check("five_ovf_pre", 8'(overflow), 8'd0);
    keys[8] = 1'b0;
    step(8);
    keys[8] = 1'b1;
    step(5);
    check("five_ovf_e5", 8'(overflow), 8'd0);
    step(1);
    check("five_ovf_set", 8'(overflow), 8'd1);
    ev_ready = 1'b1;
    step(1);
    check("drain_1", 8'(ev_code), 8'd1);
    step(1);
    check("drain_7", 8'(ev_code), 8'd7);
    step(1);
    check("drain_3", 8'(ev_code), 8'd3);
    step(1);
    check("drain_9", 8'(ev_code), 8'd9);
    check("drain_9_valid", 8'(ev_valid), 8'd1);
    step(1);
    check("drain_empty", 8'(ev_valid), 8'd0);
    check("ovf_sticky", 8'(overflow), 8'd1);
    ev_ready = 1'b0;
    keys     = 9'h100;
    step(8);

    // Reset with two events queued and key 9 held.
    keys[0] = 1'b1; step(8);
    keys[3] = 1'b1; step(8);
    check("pre_rst_valid", 8'(ev_valid), 8'd1);
    check("pre_rst_head", 8'(ev_code), 8'd1);
    keys  = 9'h100;
    rst_n = 1'b0;
    step(1);
    check("mid_rst_valid", 8'(ev_valid), 8'd0);
    check("mid_rst_held", 8'(held_code), 8'd0);
    check("mid_rst_ovf", 8'(overflow), 8'd0);
    rst_n = 1'b1;
    step(10);
    check("post_rst_held", 8'(held_code), 8'd9);
    check("post_rst_valid", 8'(ev_valid), 8'd0);
    step(20);
    check("post_rst_noevent", 8'(ev_valid), 8'd0);
    keys = '0;
    step(8);
    check("k9_rel_held", 8'(held_code), 8'd0);
    check("k9_rel_valid", 8'(ev_valid), 8'd0);
    keys[8] = 1'b1;
    step(6);
    check("k9_repress_e6", 8'(ev_valid), 8'd0);
    step(1);
    check("k9_repress_valid", 8'(ev_valid), 8'd1);
    check("k9_repress_code", 8'(ev_code), 8'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
